fwd_unit_param: RTL



---
 rtl/fwd_unit_param_pkg.sv | 29 ++
 rtl/fwd_unit_param_if.sv | 54 +++++
 rtl/fwd_unit_param_match_sel.sv | 62 ++++++
 rtl/fwd_unit_param.sv | 114 +++++++++++
 4 files changed

// File: rtl/fwd_unit_param_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the operand-forwarding / hazard unit:
//   - DATA_W / ADDR_W   default data and register-address widths
//   - fwd_entry_t       one producer history entry (valid, ready, addr, data)
//   - stage_w()         width of a stage index for a given history depth
//   - ZERO_REG_ADDR     architectural zero register address
// -----------------------------------------------------------------------------
package fwd_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    // Architectural zero register; excluded from forwarding when enabled.
    localparam int ZERO_REG_ADDR = 0;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fwd_entry_t;

    // One extra bit over clog2 so DEPTH=1 still gets a one-bit index.
    function automatic int stage_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fwd_unit_param_if.sv
// -----------------------------------------------------------------------------
// fwd_unit_param_if
// Bundles the producer push, load fill, source lookup and forwarding result
// signals of fwd_unit_param.
//   master : pipeline side (drives push/fill/source, receives forward results)
//   slave  : forwarding unit side
// -----------------------------------------------------------------------------
interface fwd_unit_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 3
);
    import fwd_pkg::*;

    localparam int STAGE_W = stage_w(DEPTH);

    logic              hold;
    logic              flush;
    logic              ex_valid;
    logic              ex_wr_en;
    logic              ex_is_load;
    logic [ADDR_W-1:0] ex_wr_addr;
    logic [DATA_W-1:0] ex_result;
    logic              ld_fill_valid;
    logic [DATA_W-1:0] ld_fill_data;
    logic              src1_used;
    logic [ADDR_W-1:0] src1_addr;
    logic              src2_used;
    logic [ADDR_W-1:0] src2_addr;
    logic               fwd1_hit;
    logic [STAGE_W-1:0] fwd1_stage;
    logic [DATA_W-1:0]  fwd1_data;
    logic               fwd2_hit;
    logic [STAGE_W-1:0] fwd2_stage;
    logic [DATA_W-1:0]  fwd2_data;
    logic               hazard_stall;

    modport master (
        output hold, flush, ex_valid, ex_wr_en, ex_is_load, ex_wr_addr, ex_result,
        output ld_fill_valid, ld_fill_data,
        output src1_used, src1_addr, src2_used, src2_addr,
        input  fwd1_hit, fwd1_stage, fwd1_data,
        input  fwd2_hit, fwd2_stage, fwd2_data, hazard_stall
    );

    modport slave (
        input  hold, flush, ex_valid, ex_wr_en, ex_is_load, ex_wr_addr, ex_result,
        input  ld_fill_valid, ld_fill_data,
        input  src1_used, src1_addr, src2_used, src2_addr,
        output fwd1_hit, fwd1_stage, fwd1_data,
        output fwd2_hit, fwd2_stage, fwd2_data, hazard_stall
    );

endinterface

// File: rtl/fwd_unit_param_match_sel.sv
// -----------------------------------------------------------------------------
// fwd_match_sel
// DEPTH-way address compare against the producer history plus a youngest-first
// priority select for a single source operand.
//   used, addr       : source operand request
//   ent_*            : flattened history (index 0 = youngest)
//   hit/stage/data   : forwarding result when the winning entry is ready
//   not_ready        : winning entry is a load still waiting for its data
// -----------------------------------------------------------------------------
module fwd_match_sel
    import fwd_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int DEPTH       = 3,
    parameter int ZERO_REG_EN = 0,
    parameter int STAGE_W     = 3
) (
    input  logic                         used,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DEPTH-1:0]             ent_valid,
    input  logic [DEPTH-1:0]             ent_ready,
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    output logic                         hit,
    output logic [STAGE_W-1:0]           stage,
    output logic [DATA_W-1:0]            data,
    output logic                         not_ready
);

    logic               found;
    logic               win_ready;
    logic [STAGE_W-1:0] win_stage;
    logic [DATA_W-1:0]  win_data;

    // Scan oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        found     = 1'b0;
        win_ready = 1'b0;
        win_stage = '0;
        win_data  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (used && ent_valid[i] && (ent_addr[i] == addr) &&
                ((ZERO_REG_EN == 0) || (ent_addr[i] != ADDR_W'(ZERO_REG_ADDR)))) begin
                found     = 1'b1;
                win_ready = ent_ready[i];
                win_stage = STAGE_W'(i);
                win_data  = ent_data[i];
            end
        end
    end

    // A pending-load winner blocks forwarding entirely; older ready copies of
    // the same register are stale and must not be used.
    always_comb begin
        hit       = found & win_ready;
        not_ready = found & ~win_ready;
        stage     = found ? win_stage : '0;
        data      = (found && win_ready) ? win_data : '0;
    end

endmodule

// File: rtl/fwd_unit_param.sv
// -----------------------------------------------------------------------------
// fwd_unit_param
// Operand-forwarding and load-use hazard unit. Keeps a shift history of the
// last DEPTH register-writing producers and, for each of two decode sources,
// forwards the youngest matching ready result or raises a stall if that
// youngest match is a load still awaiting data.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fwd_unit_param_if slave (push, fill, sources, results)
// -----------------------------------------------------------------------------
module fwd_unit_param
    import fwd_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int DEPTH       = 3,
    parameter int ZERO_REG_EN = 0
) (
    input  logic             clk,
    input  logic             reset,
    fwd_unit_param_if.slave  bus
);

    localparam int STAGE_W = stage_w(DEPTH);

    logic [DEPTH-1:0]             h_valid;
    logic [DEPTH-1:0]             h_ready;
    logic [DEPTH-1:0][ADDR_W-1:0] h_addr;
    logic [DEPTH-1:0][DATA_W-1:0] h_data;

    logic fill_ok;
    logic stall1;
    logic stall2;

    // A fill only ever targets the current youngest entry, and only if that
    // entry is a live load still waiting for its data.
    assign fill_ok = bus.ld_fill_valid & h_valid[0] & ~h_ready[0];

    // History update: flush beats everything, hold freezes the history (the
    // pending load in entry 0 may still be filled in place), otherwise shift
    // by one and push the current producer. A fill that coincides with a
    // shift follows its entry into slot 1; with DEPTH=1 it falls off the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_valid <= '0;
            h_ready <= '0;
            h_addr  <= '0;
            h_data  <= '0;
        end else if (bus.flush) begin
            h_valid <= '0;
        end else if (bus.hold) begin
            if (fill_ok) begin
                h_ready[0] <= 1'b1;
                h_data[0]  <= bus.ld_fill_data;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                h_valid[i] <= h_valid[i-1];
                h_addr[i]  <= h_addr[i-1];
                if ((i == 1) && fill_ok) begin
                    h_ready[i] <= 1'b1;
                    h_data[i]  <= bus.ld_fill_data;
                end else begin
                    h_ready[i] <= h_ready[i-1];
                    h_data[i]  <= h_data[i-1];
                end
            end
            h_valid[0] <= bus.ex_valid & bus.ex_wr_en;
            h_ready[0] <= ~bus.ex_is_load;
            h_addr[0]  <= bus.ex_wr_addr;
            h_data[0]  <= bus.ex_is_load ? '0 : bus.ex_result;
        end
    end

    fwd_match_sel #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .ZERO_REG_EN (ZERO_REG_EN),
        .STAGE_W     (STAGE_W)
    ) u_sel1 (
        .used      (bus.src1_used),
        .addr      (bus.src1_addr),
        .ent_valid (h_valid),
        .ent_ready (h_ready),
        .ent_addr  (h_addr),
        .ent_data  (h_data),
        .hit       (bus.fwd1_hit),
        .stage     (bus.fwd1_stage),
        .data      (bus.fwd1_data),
        .not_ready (stall1)
    );

    fwd_match_sel #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .ZERO_REG_EN (ZERO_REG_EN),
        .STAGE_W     (STAGE_W)
    ) u_sel2 (
        .used      (bus.src2_used),
        .addr      (bus.src2_addr),
        .ent_valid (h_valid),
        .ent_ready (h_ready),
        .ent_addr  (h_addr),
        .ent_data  (h_data),
        .hit       (bus.fwd2_hit),
        .stage     (bus.fwd2_stage),
        .data      (bus.fwd2_data),
        .not_ready (stall2)
    );

    assign bus.hazard_stall = stall1 | stall2;

endmodule
